// File: rtl/apb_master_q_if.sv
// Bundle of the command/response stream and APB bus signals around apb_master_q.
// The master modport is the requester's view; slave is the command source plus APB slave.
interface apb_master_q_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic                cmd_write_i;
    logic [ADDR_W-1:0]   cmd_addr_i;
    logic [DATA_W-1:0]   cmd_wdata_i;
    logic [DATA_W/8-1:0] cmd_strb_i;

    logic                rsp_valid_o;
    logic [DATA_W-1:0]   rsp_rdata_o;
    logic                rsp_err_o;
    logic                rsp_tmo_o;

    logic                psel_o;
    logic                penable_o;
    logic                pwrite_o;
    logic [ADDR_W-1:0]   paddr_o;
    logic [DATA_W-1:0]   pwdata_o;
    logic [DATA_W/8-1:0] pstrb_o;
    logic                pready_i;
    logic                pslverr_i;
    logic [DATA_W-1:0]   prdata_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        input  pready_i, pslverr_i, prdata_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
        output pready_i, pslverr_i, prdata_i
    );
endinterface

// File: rtl/apb_master_q.sv
// APB3/APB4 requester: converts a valid/ready command stream into APB transfers and
// returns one registered response per command, with an ACCESS-phase watchdog.
module apb_master_q #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    apb_master_q_if.master bus
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_wdog;
    logic                w_ready;
    logic                w_accept;
    logic                w_done;
    logic                w_tmo;

    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [DATA_W/8-1:0] r_pstrb;

    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_rsp_tmo;

    // Timeout fires on a stalled ACCESS cycle number TIMEOUT; a late pready still wins.
    assign w_done   = (r_state == S_ACCESS) && bus.pready_i;
    assign w_tmo    = (TIMEOUT > 0) && (r_state == S_ACCESS) && !bus.pready_i &&
                      (r_wdog == CNT_W'(TIMEOUT - 1));
    assign w_ready  = !reset && ((r_state == S_IDLE) || w_done);
    assign w_accept = bus.cmd_valid_i && w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: begin
                if (w_done) begin
                    w_next = bus.cmd_valid_i ? S_SETUP : S_IDLE;
                end else if (w_tmo) begin
                    w_next = S_IDLE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (r_state == S_SETUP) begin
            r_wdog <= '0;
        end else if ((r_state == S_ACCESS) && !bus.pready_i && !w_tmo) begin
            r_wdog <= r_wdog + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_accept) begin
            r_paddr  <= bus.cmd_addr_i;
            r_pwrite <= bus.cmd_write_i;
            r_pwdata <= bus.cmd_wdata_i;
            r_pstrb  <= bus.cmd_write_i ? bus.cmd_strb_i : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done || w_tmo;
            r_rsp_rdata <= (w_done && !r_pwrite) ? bus.prdata_i : '0;
            r_rsp_err   <= w_done ? bus.pslverr_i : w_tmo;
            r_rsp_tmo   <= w_tmo;
        end
    end

    assign bus.cmd_ready_o = w_ready;
    assign bus.psel_o      = (r_state != S_IDLE);
    assign bus.penable_o   = (r_state == S_ACCESS);
    assign bus.pwrite_o    = r_pwrite;
    assign bus.paddr_o     = r_paddr;
    assign bus.pwdata_o    = r_pwdata;
    assign bus.pstrb_o     = r_pstrb;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.rsp_tmo_o   = r_rsp_tmo;

endmodule

// File: tb/tb_apb_master_q.sv
// Directed self-checking bench for apb_master_q (TIMEOUT=4): write, wait-state read,
// back-to-back, watchdog abort, PSLVERR and mid-transfer reset.
module tb_apb_master_q;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    apb_master_q_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_q #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic write, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb);
        bus.cmd_valid_i = valid;
        bus.cmd_write_i = write;
        bus.cmd_addr_i  = addr;
        bus.cmd_wdata_i = wdata;
        bus.cmd_strb_i  = strb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRsp(input string tag, input logic v, input logic [31:0] d,
                            input logic e, input logic t);
        checkOutput({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'(v));
        checkOutput({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata_o), 64'(d));
        checkOutput({tag, "_rsp_err"},   64'(bus.rsp_err_o),   64'(e));
        checkOutput({tag, "_rsp_tmo"},   64'(bus.rsp_tmo_o),   64'(t));
    endtask

    task automatic checkBus(input string tag, input logic sel, input logic en,
                            input logic [31:0] addr, input logic wr, input logic [3:0] strb);
        checkOutput({tag, "_psel"},    64'(bus.psel_o),    64'(sel));
        checkOutput({tag, "_penable"}, 64'(bus.penable_o), 64'(en));
        checkOutput({tag, "_paddr"},   64'(bus.paddr_o),   64'(addr));
        checkOutput({tag, "_pwrite"},  64'(bus.pwrite_o),  64'(wr));
        checkOutput({tag, "_pstrb"},   64'(bus.pstrb_o),   64'(strb));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
        bus.prdata_i  = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset state: everything low, including cmd_ready while reset is held
        checkOutput("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
        checkBus("rst", 1'b0, 1'b0, 32'h0, 1'b0, 4'h0);
        checkOutput("rst_pwdata", 64'(bus.pwdata_o), 64'd0);
        checkRsp("rst", 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("idle_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);

        // Zero-wait write
        bus.pready_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hCAFE, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkBus("wr_setup", 1'b1, 1'b0, 32'h10, 1'b1, 4'hF);
        checkOutput("wr_setup_pwdata", 64'(bus.pwdata_o), 64'hCAFE);
        checkOutput("wr_setup_ready", 64'(bus.cmd_ready_o), 64'd0);
        checkOutput("wr_setup_rsp", 64'(bus.rsp_valid_o), 64'd0);
        tick();
        checkBus("wr_access", 1'b1, 1'b1, 32'h10, 1'b1, 4'hF);
        checkOutput("wr_access_rsp", 64'(bus.rsp_valid_o), 64'd0);
        tick();
        checkBus("wr_idle", 1'b0, 1'b0, 32'h10, 1'b1, 4'hF);
        checkRsp("wr", 1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        checkRsp("wr_after", 1'b0, 32'h0, 1'b0, 1'b0);

        // Read with three wait states; pready on 4th ACCESS cycle beats the watchdog
        bus.pready_i = 1'b0;
        bus.prdata_i = 32'hDEAD;
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h5A5A, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkBus("rd_setup", 1'b1, 1'b0, 32'h20, 1'b0, 4'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkBus($sformatf("rd_wait%0d", i), 1'b1, 1'b1, 32'h20, 1'b0, 4'h0);
            checkOutput($sformatf("rd_wait%0d_ready", i), 64'(bus.cmd_ready_o), 64'd0);
            checkOutput($sformatf("rd_wait%0d_rsp", i), 64'(bus.rsp_valid_o), 64'd0);
        end
        tick();
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'h1234;
        #1;
        checkBus("rd_last", 1'b1, 1'b1, 32'h20, 1'b0, 4'h0);
        checkOutput("rd_last_ready", 64'(bus.cmd_ready_o), 64'd1);
        tick();
        bus.prdata_i = 32'h0;
        checkOutput("rd_idle_psel", 64'(bus.psel_o), 64'd0);
        checkRsp("rd", 1'b1, 32'h1234, 1'b0, 1'b0);

        // Back-to-back: write then read, ACCESS goes straight to SETUP
        bus.prdata_i = 32'h5555;
        applyStimulus(1'b1, 1'b1, 32'h30, 32'h11, 4'h3);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h22, 4'hF);
        checkBus("b2b_setup1", 1'b1, 1'b0, 32'h30, 1'b1, 4'h3);
        checkOutput("b2b_setup1_ready", 64'(bus.cmd_ready_o), 64'd0);
        tick();
        checkBus("b2b_access1", 1'b1, 1'b1, 32'h30, 1'b1, 4'h3);
        checkOutput("b2b_access1_ready", 64'(bus.cmd_ready_o), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.prdata_i = 32'hBEEF;
        #1;
        checkBus("b2b_setup2", 1'b1, 1'b0, 32'h40, 1'b0, 4'h0);
        checkRsp("b2b_1", 1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("b2b_gap_rsp", 64'(bus.rsp_valid_o), 64'd0);
        tick();
        checkOutput("b2b_idle_psel", 64'(bus.psel_o), 64'd0);
        checkRsp("b2b_2", 1'b1, 32'hBEEF, 1'b0, 1'b0);

        // Watchdog abort after four stalled ACCESS cycles
        bus.pready_i = 1'b0;
        bus.prdata_i = 32'h7777;
        applyStimulus(1'b1, 1'b0, 32'h50, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("tmo_c%0d_penable", i), 64'(bus.penable_o), 64'd1);
            checkOutput($sformatf("tmo_c%0d_ready", i), 64'(bus.cmd_ready_o), 64'd0);
            checkOutput($sformatf("tmo_c%0d_rsp", i), 64'(bus.rsp_valid_o), 64'd0);
        end
        tick();
        checkBus("tmo_idle", 1'b0, 1'b0, 32'h50, 1'b0, 4'h0);
        checkOutput("tmo_idle_ready", 64'(bus.cmd_ready_o), 64'd1);
        checkRsp("tmo", 1'b1, 32'h0, 1'b1, 1'b1);
        tick();
        checkRsp("tmo_after", 1'b0, 32'h0, 1'b0, 1'b0);

        // PSLVERR on a write
        bus.pready_i  = 1'b1;
        bus.pslverr_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h60, 32'hABCD, 4'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        bus.pslverr_i = 1'b0;
        checkRsp("slverr", 1'b1, 32'h0, 1'b1, 1'b0);

        // Reset asserted during ACCESS drops the transfer with no response
        bus.pready_i = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h70, 32'h9999, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("mid_access_penable", 64'(bus.penable_o), 64'd1);
        reset = 1'b1;
        #1;
        checkBus("mid_rst", 1'b0, 1'b0, 32'h0, 1'b0, 4'h0);
        checkOutput("mid_rst_pwdata", 64'(bus.pwdata_o), 64'd0);
        checkOutput("mid_rst_ready", 64'(bus.cmd_ready_o), 64'd0);
        checkRsp("mid_rst", 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        bus.pready_i = 1'b1;
        tick();
        checkOutput("post_rst_psel", 64'(bus.psel_o), 64'd0);
        checkOutput("post_rst_rsp", 64'(bus.rsp_valid_o), 64'd0);
        tick();
        checkOutput("post_rst_rsp2", 64'(bus.rsp_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
